// File: rtl/axi_merge_sched.sv
// ============================================================================
// Module   : axi_merge_sched
// Purpose  : Two-master AXI merge scheduler with independent write and read
//            round-robin arbiters. `AXI_ARB_TIMEOUT_EN adds response watchdogs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_merge_sched #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [1:0] m_awvalid,
    input  logic [1:0] m_wvalid,
    input  logic [1:0] m_arvalid,
    input  logic       S_awready,
    input  logic       S_wready,
    input  logic       S_arready,
    input  logic       S_bvalid,
    input  logic       S_bready,
    input  logic       S_rvalid,
    input  logic       S_rready,
    input  logic       S_rlast,
    output logic [1:0] wr_gnt,
    output logic [1:0] rd_gnt,
    output logic       aw_en,
    output logic       w_en,
    output logic       ar_en,
    output logic       wr_tmo,
    output logic       rd_tmo
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_t;

    wr_state_t  wr_state_q, wr_state_d;
    rd_state_t  rd_state_q, rd_state_d;
    logic [1:0] wr_gnt_q, wr_gnt_d, rd_gnt_q, rd_gnt_d;
    logic       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic       w_wr_expire, w_rd_expire;
    logic [1:0] w_wr_pick, w_rd_pick;

    // Pointer holds the last winner; on contention the other master wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return last ? 2'b01 : 2'b10;
        end
        return req;
    endfunction

    assign w_wr_pick = rr_pick(m_awvalid, wr_ptr_q);
    assign w_rd_pick = rr_pick(m_arvalid, rd_ptr_q);
    assign wr_gnt    = wr_gnt_q;
    assign rd_gnt    = rd_gnt_q;

`ifdef AXI_ARB_TIMEOUT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = (wr_state_q == W_IDLE) ? 16'd0 : wr_cnt_q + 16'd1;
        rd_cnt_d = (rd_state_q == R_IDLE) ? 16'd0 : rd_cnt_q + 16'd1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign w_wr_expire = (wr_state_q != W_IDLE) && (wr_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
    assign w_rd_expire = (rd_state_q != R_IDLE) && (rd_cnt_q >= 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
    assign w_wr_expire = 1'b0;
    assign w_rd_expire = 1'b0;
`endif

    // Write path: AW and W complete independently, then wait for B.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_en      = 1'b0;
        w_en       = 1'b0;
        wr_tmo     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (|m_awvalid) begin
                    wr_state_d = W_XFER;
                    wr_gnt_d   = w_wr_pick;
                    wr_ptr_d   = w_wr_pick[1];
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end
            end
            W_XFER: begin
                aw_en     = !aw_done_q;
                w_en      = !w_done_q;
                aw_done_d = aw_done_q | (S_awready & !aw_done_q);
                w_done_d  = w_done_q | (S_wready & !w_done_q);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end else if (w_wr_expire) begin
                    wr_state_d = W_IDLE;
                    wr_gnt_d   = 2'b00;
                    wr_ptr_d   = wr_gnt_q[1];
                    wr_tmo     = 1'b1;
                end
            end
            W_RESP: begin
                if (S_bvalid && S_bready) begin
                    wr_state_d = W_IDLE;
                    wr_gnt_d   = 2'b00;
                end else if (w_wr_expire) begin
                    wr_state_d = W_IDLE;
                    wr_gnt_d   = 2'b00;
                    wr_ptr_d   = wr_gnt_q[1];
                    wr_tmo     = 1'b1;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
                wr_gnt_d   = 2'b00;
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_ptr_d   = rd_ptr_q;
        ar_en      = 1'b0;
        rd_tmo     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (|m_arvalid) begin
                    rd_state_d = R_ADDR;
                    rd_gnt_d   = w_rd_pick;
                    rd_ptr_d   = w_rd_pick[1];
                end
            end
            R_ADDR: begin
                ar_en = 1'b1;
                if (S_arready) begin
                    rd_state_d = R_DATA;
                end else if (w_rd_expire) begin
                    rd_state_d = R_IDLE;
                    rd_gnt_d   = 2'b00;
                    rd_ptr_d   = rd_gnt_q[1];
                    rd_tmo     = 1'b1;
                end
            end
            R_DATA: begin
                if (S_rvalid && S_rready && S_rlast) begin
                    rd_state_d = R_IDLE;
                    rd_gnt_d   = 2'b00;
                end else if (w_rd_expire) begin
                    rd_state_d = R_IDLE;
                    rd_gnt_d   = 2'b00;
                    rd_ptr_d   = rd_gnt_q[1];
                    rd_tmo     = 1'b1;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                rd_gnt_d   = 2'b00;
            end
        endcase
    end

    // m_wvalid is steered by the grant outside this block.
    logic [1:0] w_unused_wvalid;
    assign w_unused_wvalid = m_wvalid;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            wr_gnt_q   <= 2'b00;
            rd_gnt_q   <= 2'b00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/axi_merge_sched.md
AXI_MERGE_SCHED -- requirements
Module: axi_merge_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: slave-response watchdog limit in cycles; legal range 2..65535; used only when AXI_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port ACLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port ARESET  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have port m_awvalid  input  2  AW request per master; bit1 = M1, bit0 = M0.
REQ-005 SHALL have port m_wvalid  input  2  W valid per master.
REQ-006 SHALL have port m_arvalid  input  2  AR request per master.
REQ-007 SHALL have ports S_awready, S_wready, S_arready  input  1 each  slave address/data ready.
REQ-008 SHALL have ports S_bvalid, S_bready  input  1 each  write response handshake, observed on the merged bus.
REQ-009 SHALL have ports S_rvalid, S_rready, S_rlast  input  1 each  read data handshake, observed on the merged bus.
REQ-010 SHALL have port wr_gnt  output  2  one-hot write grant, or 0; steers the AW, W and B muxes.
REQ-011 SHALL have port rd_gnt  output  2  one-hot read grant, or 0; steers the AR and R muxes.
REQ-012 SHALL have ports aw_en, w_en, ar_en  output  1 each  gate forwarding of the granted valid to the slave.
REQ-013 SHALL have ports wr_tmo, rd_tmo  output  1 each  single-cycle watchdog expiry pulses.

Function
REQ-014 SHALL run the write FSM and the read FSM independently; both SHALL be able to hold grants in the same cycle.
REQ-015 Write FSM SHALL have states W_IDLE, W_XFER and W_RESP.
REQ-016 W_IDLE -> W_XFER on any m_awvalid bit; wr_gnt SHALL be registered and SHALL be visible the cycle after the request (1-cycle latency).
REQ-017 In W_XFER: aw_en = !aw_done and w_en = !w_done; aw_done SHALL set on S_awready&&aw_en; w_done SHALL set on S_wready&&w_en.
REQ-018 AW and W SHALL complete in either order or in the same cycle; the FSM SHALL move to W_RESP the cycle after both flags are set.
REQ-019 W_RESP -> W_IDLE on S_bvalid&&S_bready; wr_gnt SHALL clear in that transition.
REQ-020 Read FSM SHALL have states R_IDLE, R_ADDR and R_DATA.
REQ-021 Read FSM transitions: R_IDLE -> R_ADDR on any m_arvalid bit (registered rd_gnt); R_ADDR -> R_DATA on S_arready; R_DATA -> R_IDLE on S_rvalid&&S_rready&&S_rlast.
REQ-022 ar_en SHALL be 1 only in R_ADDR.
REQ-023 Each path SHALL use round-robin arbitration with a 1-bit last-winner pointer.
REQ-024 When both masters request, the non-last winner SHALL be granted; a single requester SHALL be granted regardless of the pointer.
REQ-025 The pointer SHALL update only on grant; a grant SHALL hold until its transaction ends, and a request withdrawn after grant SHALL NOT release it.
REQ-026 A new grant SHALL NOT issue in the cycle a transaction ends; the minimum gap between grants on one path is 1 idle cycle.

Reset
REQ-027 ARESET high SHALL immediately force W_IDLE and R_IDLE, set wr_gnt = rd_gnt = 0 and aw_en = w_en = ar_en = 0, clear wr_tmo, rd_tmo, aw_done, w_done and both counters, and set both pointers to M0.
REQ-028 Consequently, the first contended grant after reset SHALL go to M1.
REQ-029 Reset asserted mid-transaction SHALL abandon that transaction with no error pulse.

Configuration
REQ-030 With macro AXI_ARB_TIMEOUT_EN defined, a per-path counter SHALL clear on entry to W_XFER/R_ADDR and count each cycle in W_XFER, W_RESP, R_ADDR and R_DATA.
REQ-031 With AXI_ARB_TIMEOUT_EN defined, at count TIMEOUT_CYCLES-1 the FSM SHALL return to idle, clear its grant, pulse wr_tmo/rd_tmo for 1 cycle and advance the pointer.
REQ-032 With AXI_ARB_TIMEOUT_EN defined, a completing handshake in the expiry cycle SHALL win; no pulse is then generated.
REQ-033 Without AXI_ARB_TIMEOUT_EN, no counters SHALL exist, wr_tmo and rd_tmo SHALL be constant 0, and the FSMs SHALL wait indefinitely.

Verification
REQ-034 m_awvalid=2'b11 from reset, slave always ready -> wr_gnt=2'b10 at cycle 1; after B handshake, 1 idle cycle, then wr_gnt=2'b01.
REQ-035 W handshake 3 cycles before AW handshake -> W_RESP entered the cycle after the AW handshake; w_en=0 while aw_en=1.
REQ-036 Concurrent M0 read and M1 write -> rd_gnt=2'b01 and wr_gnt=2'b10 both asserted simultaneously.
REQ-037 Read with S_rlast on beat 4 of 4 -> rd_gnt held through beats 1-3, cleared after beat 4.
REQ-038 AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, S_bvalid held 0 -> wr_tmo pulses 1 cycle at count 7, wr_gnt=0 the next cycle; undefined macro -> grant held 100+ cycles.
REQ-039 ARESET pulsed while in R_DATA -> rd_gnt=0 and ar_en=0 asynchronously, no rd_tmo pulse.
